// File: rtl/conv_kernel_win.sv
// rtl/conv_kernel_win.sv - 5x5 sliding window with border padding; define CONV_KWIN_REPLICATE_EN for edge replication instead of zero pad
module conv_kernel_win #(
  parameter int PIXEL_W = 8
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [4:0]             col_push_i,
  input  logic [7:0]             col_pos_i,
  input  logic [5*PIXEL_W-1:0]   col_data_i,
  input  logic                   flush_i,
  output logic                   stall_o,
  output logic                   m_tvalid_o,
  input  logic                   m_tready_i,
  output logic [25*PIXEL_W-1:0]  m_tdata_o,
  output logic                   m_tuser_o,
  output logic                   m_tlast_o
);

  localparam int SLOT_W = 5 * PIXEL_W;

  logic [4:0][SLOT_W-1:0] win_q, win_n;
  logic [4:0]             vld_q, vld_n;
  logic [4:0][7:0]        pos_q, pos_n;
  logic [1:0]             flush_cnt_q;

  logic                   push, bubble, shift;
  logic [7:0]             ctr;
  logic [4:0]             col_pad, row_pad;
  logic [PIXEL_W-1:0]     pix [5][5];
  logic [25*PIXEL_W-1:0]  win_pad;

  assign push    = |col_push_i;
  assign stall_o = m_tvalid_o & ~m_tready_i;
  assign bubble  = ~push & (flush_cnt_q != 2'd0);
  assign shift   = (push | bubble) & ~stall_o;

  // Centre flags {w2,w1,e2,e1,n2,n1,s2,s1} come from the post-shift centre slot
  assign ctr = pos_n[2];

  // Column pad mask: flags, plus any empty slot around the centre
  assign col_pad[0] = ctr[7] | ctr[6] | ~vld_n[0];
  assign col_pad[1] = ctr[7] | ~vld_n[1];
  assign col_pad[2] = 1'b0;
  assign col_pad[3] = ctr[5] | ~vld_n[3];
  assign col_pad[4] = ctr[5] | ctr[4] | ~vld_n[4];

  assign row_pad[0] = ctr[3] | ctr[2];
  assign row_pad[1] = ctr[3];
  assign row_pad[2] = 1'b0;
  assign row_pad[3] = ctr[1];
  assign row_pad[4] = ctr[1] | ctr[0];

  // Next-state window: slots move toward slot 0, new column (or empty bubble) enters slot 4
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      win_n[k] = win_q[k+1];
      vld_n[k] = vld_q[k+1];
      pos_n[k] = pos_q[k+1];
    end
    win_n[4] = push ? col_data_i : '0;
    vld_n[4] = push;
    pos_n[4] = push ? col_pos_i : '0;
  end

  // Pad the next-state window: columns first, then rows, working outward from the centre
  always_comb begin
    win_pad = '0;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 5; r++)
        pix[c][r] = win_n[c][r*PIXEL_W +: PIXEL_W];
`ifdef CONV_KWIN_REPLICATE_EN
    for (int r = 0; r < 5; r++) begin
      if (col_pad[1]) pix[1][r] = pix[2][r];
      if (col_pad[0]) pix[0][r] = pix[1][r];
      if (col_pad[3]) pix[3][r] = pix[2][r];
      if (col_pad[4]) pix[4][r] = pix[3][r];
    end
    for (int c = 0; c < 5; c++) begin
      if (row_pad[1]) pix[c][1] = pix[c][2];
      if (row_pad[0]) pix[c][0] = pix[c][1];
      if (row_pad[3]) pix[c][3] = pix[c][2];
      if (row_pad[4]) pix[c][4] = pix[c][3];
    end
`else
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 5; r++)
        if (col_pad[c] || row_pad[r]) pix[c][r] = '0;
`endif
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 5; r++)
        win_pad[(5*c+r)*PIXEL_W +: PIXEL_W] = pix[c][r];
  end

  // Window slot storage advances only on an accepted shift
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      win_q <= '0;
      vld_q <= '0;
      pos_q <= '0;
    end else if (shift) begin
      win_q <= win_n;
      vld_q <= vld_n;
      pos_q <= pos_n;
    end
  end

  // Flush counter: a new flush reloads, each bubble shift consumes one
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      flush_cnt_q <= 2'd0;
    end else if (flush_i) begin
      flush_cnt_q <= 2'd2;
    end else if (shift && bubble) begin
      flush_cnt_q <= flush_cnt_q - 2'd1;
    end
  end

  // Output register: load the padded window on shift, retire it when taken with nothing new
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tuser_o  <= 1'b0;
      m_tlast_o  <= 1'b0;
    end else if (shift) begin
      m_tvalid_o <= vld_n[2];
      m_tdata_o  <= win_pad;
      m_tuser_o  <= ctr[7] & ctr[3];
      m_tlast_o  <= ctr[5];
    end else if (m_tready_i) begin
      m_tvalid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_kernel_win.sv
// tb/tb_conv_kernel_win.sv - directed table-driven bench for conv_kernel_win (zero or CONV_KWIN_REPLICATE_EN build)
module tb_conv_kernel_win;

  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            arst_n;
  logic [4:0]      col_push;
  logic [7:0]      col_pos;
  logic [5*PW-1:0] col_data;
  logic            flush;
  logic            stall;
  logic            tvalid;
  logic            tready;
  logic [25*PW-1:0] tdata;
  logic            tuser;
  logic            tlast;

  int checks = 0;
  int errors = 0;

  typedef logic [4:0][7:0] row_t;
  typedef struct {
    logic [4:0] push;
    int         col;
    logic       flush;
    logic       ev;
    logic       eu;
    logic       el;
    logic       cd;
    row_t       r2;
  } vec_t;

  vec_t vecs[9];

  conv_kernel_win #(.PIXEL_W(PW)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .col_push_i (col_push),
    .col_pos_i  (col_pos),
    .col_data_i (col_data),
    .flush_i    (flush),
    .stall_o    (stall),
    .m_tvalid_o (tvalid),
    .m_tready_i (tready),
    .m_tdata_o  (tdata),
    .m_tuser_o  (tuser),
    .m_tlast_o  (tlast)
  );

  always #5 clk = ~clk;

  function automatic logic [5*PW-1:0] cdata(int c);
    logic [5*PW-1:0] d;
    for (int r = 0; r < 5; r++) d[r*PW +: PW] = 8'(10*r + c + 1);
    return d;
  endfunction

  function automatic logic [7:0] cpos(int c);
    logic [7:0] p;
    case (c)
      0:       p = 8'h8A;
      1:       p = 8'h4A;
      2:       p = 8'h0A;
      3:       p = 8'h1A;
      default: p = 8'h2A;
    endcase
    return p;
  endfunction

  function automatic row_t row5(int a, int b, int c, int d, int e);
    row_t x;
    x[0] = 8'(a); x[1] = 8'(b); x[2] = 8'(c); x[3] = 8'(d); x[4] = 8'(e);
    return x;
  endfunction

  function automatic logic [25*PW-1:0] exp_win(row_t v);
    logic [25*PW-1:0] w;
    w = '0;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 5; r++)
`ifdef CONV_KWIN_REPLICATE_EN
        w[(5*c+r)*PW +: PW] = v[c];
`else
        w[(5*c+r)*PW +: PW] = (r == 2) ? v[c] : 8'd0;
`endif
    return w;
  endfunction

  function automatic vec_t mk(logic [4:0] p, int c, logic f, logic ev, logic eu,
                              logic el, logic cd, row_t r2);
    vec_t v;
    v.push = p; v.col = c; v.flush = f; v.ev = ev; v.eu = eu; v.el = el; v.cd = cd; v.r2 = r2;
    return v;
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [25*PW-1:0] got, input logic [25*PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] p, input int c);
    col_push = p;
    col_data = cdata(c);
    col_pos  = cpos(c);
  endtask

  initial begin
    row_t a_row, b_row, c_row;

    vecs[0] = mk(5'b00001, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, row5(0, 0, 0, 0, 0));
    vecs[1] = mk(5'b00010, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, row5(0, 0, 0, 0, 0));
    vecs[5] = mk(5'b00000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, row5(21, 22, 23, 24, 25));
`ifdef CONV_KWIN_REPLICATE_EN
    a_row = row5(21, 21, 21, 22, 23);
    b_row = row5(21, 21, 22, 23, 24);
    vecs[6] = mk(5'b00000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, row5(22, 23, 24, 25, 25));
    vecs[7] = mk(5'b00000, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, row5(23, 24, 25, 25, 25));
    vecs[8] = mk(5'b00000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, row5(23, 24, 25, 25, 25));
`else
    a_row = row5(0, 0, 21, 22, 23);
    b_row = row5(0, 21, 22, 23, 24);
    vecs[6] = mk(5'b00000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, row5(22, 23, 24, 25, 0));
    vecs[7] = mk(5'b00000, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, row5(23, 24, 25, 0, 0));
    vecs[8] = mk(5'b00000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, row5(23, 24, 25, 0, 0));
`endif
    c_row = row5(21, 22, 23, 24, 25);
    vecs[2] = mk(5'b00100, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a_row);
    vecs[3] = mk(5'b11111, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, b_row);
    vecs[4] = mk(5'b01000, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, c_row);

    // Reset with pushes present and downstream not ready
    arst_n = 1'b0;
    tready = 1'b0;
    flush  = 1'b0;
    present(5'b11111, 2);
    step();
    step();
    chk1("rst_tvalid", tvalid, 1'b0);
    chkw("rst_tdata", tdata, '0);
    chk1("rst_tuser", tuser, 1'b0);
    chk1("rst_tlast", tlast, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    arst_n = 1'b1;
    tready = 1'b1;
    present(5'b00000, 0);
    step();

    // Single-line frame followed by flush
    for (int i = 0; i < 9; i++) begin
      present(vecs[i].push, vecs[i].col);
      flush = vecs[i].flush;
      step();
      chk1($sformatf("frame%0d_tvalid", i), tvalid, vecs[i].ev);
      chk1($sformatf("frame%0d_tuser", i), tuser, vecs[i].eu);
      chk1($sformatf("frame%0d_tlast", i), tlast, vecs[i].el);
      if (vecs[i].cd) chkw($sformatf("frame%0d_tdata", i), tdata, exp_win(vecs[i].r2));
    end
    flush = 1'b0;

    // Back-pressure: window held, pushes refused while stalled
    for (int c = 0; c < 3; c++) begin
      present(5'b00001, c);
      step();
    end
    chk1("bp_first_tvalid", tvalid, 1'b1);
    chk1("bp_first_tuser", tuser, 1'b1);
    tready = 1'b0;
    present(5'b00001, 3);
    #1;
    chk1("bp_stall_comb", stall, 1'b1);
    for (int n = 0; n < 4; n++) begin
      step();
      chk1($sformatf("bp%0d_stall", n), stall, 1'b1);
      chk1($sformatf("bp%0d_tvalid", n), tvalid, 1'b1);
      chkw($sformatf("bp%0d_tdata", n), tdata, exp_win(a_row));
    end
    tready = 1'b1;
    #1;
    chk1("bp_release_stall", stall, 1'b0);
    step();
    chk1("bp_next_tvalid", tvalid, 1'b1);
    chkw("bp_next_tdata", tdata, exp_win(b_row));
    present(5'b00001, 4);
    step();
    chkw("bp_col2_tdata", tdata, exp_win(c_row));

    // Flush into one bubble, then reset while a window is valid and one bubble remains
    present(5'b00000, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk1("mid_flush_idle_tvalid", tvalid, 1'b0);
    step();
    chk1("mid_bubble_tvalid", tvalid, 1'b1);
    arst_n = 1'b0;
    #1;
    chk1("mid_rst_tvalid", tvalid, 1'b0);
    chkw("mid_rst_tdata", tdata, '0);
    chk1("mid_rst_tlast", tlast, 1'b0);
    step();
    arst_n = 1'b1;
    step();
    chk1("mid_post_rst_tvalid", tvalid, 1'b0);

    // Restart: first window again on the third push
    for (int c = 0; c < 3; c++) begin
      present(5'b00010, c);
      step();
      chk1($sformatf("restart%0d_tvalid", c), tvalid, (c == 2));
    end
    chk1("restart_tuser", tuser, 1'b1);
    chkw("restart_tdata", tdata, exp_win(a_row));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
